// File: rtl/dist_pkg.sv
// Shared widths and the stage record carried through EX, MEM and WB
// of the distribution write-back pipeline.
package dist_pkg;

   localparam int unsigned DIST_WIDTH = 32;
   localparam int unsigned ADDR_WIDTH = 5;

   typedef struct packed {
      logic                  dregWrite;
      logic [ADDR_WIDTH-1:0] destAddr;
      logic [DIST_WIDTH-1:0] data;
   } distStage_t;

   localparam distStage_t DIST_BUBBLE = '0;

endpackage

// File: rtl/dist_regfile.sv
// Distribution register file: one write port, one combinational read port,
// r0 reads as zero, asynchronous active-low clear of every entry.
module dist_regfile #(
   parameter int unsigned DIST_WIDTH = dist_pkg::DIST_WIDTH,
   parameter int unsigned ADDR_WIDTH = dist_pkg::ADDR_WIDTH,
   parameter int unsigned NUM_REGS   = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wrEn,
   input  logic [ADDR_WIDTH-1:0] wrAddr,
   input  logic [DIST_WIDTH-1:0] wrData,
   input  logic [ADDR_WIDTH-1:0] rdAddr,
   output logic [DIST_WIDTH-1:0] rdData
);

   logic [DIST_WIDTH-1:0] regs [NUM_REGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wrEn) begin
         regs[wrAddr] <= wrData;
      end
   end

   assign rdData = (rdAddr == '0) ? '0 : regs[rdAddr];

endmodule

// File: rtl/dist_stage_pipeline.sv
// EX/MEM/WB stage registers for distribution write-back, the ID operand
// forwarding mux and the distribution register file.
module dist_stage_pipeline #(
   parameter int unsigned DIST_WIDTH = dist_pkg::DIST_WIDTH,
   parameter int unsigned ADDR_WIDTH = dist_pkg::ADDR_WIDTH,
   parameter int unsigned NUM_REGS   = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  stall,
   input  logic                  flush_ex,
   input  logic                  id_dreg_write,
   input  logic [ADDR_WIDTH-1:0] id_dest_addr,
   input  logic [ADDR_WIDTH-1:0] id_source_addr,
   input  logic [DIST_WIDTH-1:0] ex_result,
   input  logic                  ex_dfwd_sel,
   input  logic                  mem_dfwd_sel,
   output logic                  ex_dreg_write,
   output logic [ADDR_WIDTH-1:0] ex_dest_addr,
   output logic                  mem_dreg_write,
   output logic [ADDR_WIDTH-1:0] mem_dest_addr,
   output logic [DIST_WIDTH-1:0] ex_source_data,
   output logic                  wb_dreg_write
);

   import dist_pkg::*;

   // The stage record is sized by the package, so the parameters must agree with it.
   if (DIST_WIDTH != dist_pkg::DIST_WIDTH || ADDR_WIDTH != dist_pkg::ADDR_WIDTH ||
       NUM_REGS != (2 ** ADDR_WIDTH)) begin : gBadParams
      $error("dist_stage_pipeline: parameters inconsistent with dist_pkg");
   end

   distStage_t exQ, memQ, wbQ;
   logic [DIST_WIDTH-1:0] rfRdData;
   logic [DIST_WIDTH-1:0] idOperand;

   dist_regfile #(
      .DIST_WIDTH (DIST_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_REGS   (NUM_REGS)
   ) uRegfile (
      .clk    (clk),
      .rst_n  (rst_n),
      .wrEn   (wbQ.dregWrite & ~stall),
      .wrAddr (wbQ.destAddr),
      .wrData (wbQ.data),
      .rdAddr (id_source_addr),
      .rdData (rfRdData)
   );

   // Youngest producer wins; WB write-through covers the commit cycle.
   always_comb begin
      idOperand = rfRdData;
      if (ex_dfwd_sel) begin
         idOperand = ex_result;
      end else if (mem_dfwd_sel) begin
         idOperand = memQ.data;
      end else if (wbQ.dregWrite && (wbQ.destAddr == id_source_addr)) begin
         idOperand = wbQ.data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exQ  <= DIST_BUBBLE;
         memQ <= DIST_BUBBLE;
         wbQ  <= DIST_BUBBLE;
      end else begin
         // Flush overrides stall for EX only.
         if (flush_ex) begin
            exQ <= DIST_BUBBLE;
         end else if (!stall) begin
            exQ.dregWrite <= id_dreg_write && (id_dest_addr != '0);
            exQ.destAddr  <= id_dest_addr;
            exQ.data      <= idOperand;
         end
         if (!stall) begin
            memQ.dregWrite <= exQ.dregWrite;
            memQ.destAddr  <= exQ.destAddr;
            memQ.data      <= ex_result;
            wbQ            <= memQ;
         end
      end
   end

   assign ex_dreg_write  = exQ.dregWrite;
   assign ex_dest_addr   = exQ.destAddr;
   assign ex_source_data = exQ.data;
   assign mem_dreg_write = memQ.dregWrite;
   assign mem_dest_addr  = memQ.destAddr;
   assign wb_dreg_write  = wbQ.dregWrite;

endmodule

// File: tb/tb_dist_stage_pipeline.sv
// Scoreboard bench for dist_stage_pipeline: a behavioural pipeline model pushes
// expected outputs per driven cycle, popped and compared after the edge.
module tb_dist_stage_pipeline;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        flush_ex;
   logic        id_dreg_write;
   logic [4:0]  id_dest_addr;
   logic [4:0]  id_source_addr;
   logic [31:0] ex_result;
   logic        ex_dfwd_sel;
   logic        mem_dfwd_sel;
   logic        ex_dreg_write;
   logic [4:0]  ex_dest_addr;
   logic        mem_dreg_write;
   logic [4:0]  mem_dest_addr;
   logic [31:0] ex_source_data;
   logic        wb_dreg_write;

   dist_stage_pipeline dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall          (stall),
      .flush_ex       (flush_ex),
      .id_dreg_write  (id_dreg_write),
      .id_dest_addr   (id_dest_addr),
      .id_source_addr (id_source_addr),
      .ex_result      (ex_result),
      .ex_dfwd_sel    (ex_dfwd_sel),
      .mem_dfwd_sel   (mem_dfwd_sel),
      .ex_dreg_write  (ex_dreg_write),
      .ex_dest_addr   (ex_dest_addr),
      .mem_dreg_write (mem_dreg_write),
      .mem_dest_addr  (mem_dest_addr),
      .ex_source_data (ex_source_data),
      .wb_dreg_write  (wb_dreg_write)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        exW;
      logic [4:0]  exA;
      logic [31:0] exD;
      logic        memW;
      logic [4:0]  memA;
      logic        wbW;
   } expOut_t;

   expOut_t expQ[$];

   // Reference model state
   logic        mExW, mMemW, mWbW;
   logic [4:0]  mExA, mMemA, mWbA;
   logic [31:0] mExD, mMemD, mWbD;
   logic [31:0] mRf [32];

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic modelReset();
      {mExW, mMemW, mWbW} = '0;
      {mExA, mMemA, mWbA} = '0;
      {mExD, mMemD, mWbD} = '0;
      for (int i = 0; i < 32; i++) mRf[i] = '0;
      expQ.delete();
   endtask

   task automatic checkAllZero(input string tag);
      checkVal({tag, "_ex_w"}, 32'(ex_dreg_write), 32'd0);
      checkVal({tag, "_ex_a"}, 32'(ex_dest_addr), 32'd0);
      checkVal({tag, "_ex_d"}, ex_source_data, 32'd0);
      checkVal({tag, "_mem_w"}, 32'(mem_dreg_write), 32'd0);
      checkVal({tag, "_mem_a"}, 32'(mem_dest_addr), 32'd0);
      checkVal({tag, "_wb_w"}, 32'(wb_dreg_write), 32'd0);
   endtask

   // Drive one cycle, predict the post-edge outputs, then compare after the edge.
   task automatic step(input logic st, input logic fl, input logic iw, input logic [4:0] idst,
                       input logic [4:0] isrc, input logic [31:0] res, input logic es,
                       input logic ms);
      logic [31:0] opnd;
      expOut_t     e;
      expOut_t     got;
      stall = st; flush_ex = fl; id_dreg_write = iw; id_dest_addr = idst;
      id_source_addr = isrc; ex_result = res; ex_dfwd_sel = es; mem_dfwd_sel = ms;
      if (es)                          opnd = res;
      else if (ms)                     opnd = mMemD;
      else if (mWbW && mWbA == isrc)   opnd = mWbD;
      else if (isrc == 5'd0)           opnd = 32'd0;
      else                             opnd = mRf[isrc];
      if (!st) begin
         if (mWbW) mRf[mWbA] = mWbD;
         mWbW = mMemW; mWbA = mMemA; mWbD = mMemD;
         mMemW = mExW; mMemA = mExA; mMemD = res;
      end
      if (fl) begin
         mExW = 1'b0; mExA = 5'd0; mExD = 32'd0;
      end else if (!st) begin
         mExW = iw && (idst != 5'd0); mExA = idst; mExD = opnd;
      end
      e = '{exW: mExW, exA: mExA, exD: mExD, memW: mMemW, memA: mMemA, wbW: mWbW};
      expQ.push_back(e);
      @(posedge clk);
      #1;
      got = expQ.pop_front();
      checkVal("sb_ex_dreg_write", 32'(ex_dreg_write), 32'(got.exW));
      checkVal("sb_ex_dest_addr", 32'(ex_dest_addr), 32'(got.exA));
      checkVal("sb_ex_source_data", ex_source_data, got.exD);
      checkVal("sb_mem_dreg_write", 32'(mem_dreg_write), 32'(got.memW));
      checkVal("sb_mem_dest_addr", 32'(mem_dest_addr), 32'(got.memA));
      checkVal("sb_wb_dreg_write", 32'(wb_dreg_write), 32'(got.wbW));
   endtask

   task automatic bubble();
      step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
      stall = 1'b0; flush_ex = 1'b0; id_dreg_write = 1'b0; id_dest_addr = '0;
      id_source_addr = '0; ex_result = '0; ex_dfwd_sel = 1'b0; mem_dfwd_sel = 1'b0;
      modelReset();
      #3;
      checkAllZero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Every register reads zero after reset
      for (int i = 0; i < 32; i++) begin
         step(1'b0, 1'b0, 1'b0, 5'd0, 5'(i), 32'd0, 1'b0, 1'b0);
         checkVal("reset_read", ex_source_data, 32'd0);
      end

      // Commit r5 then read it back from the register file
      step(1'b0, 1'b0, 1'b1, 5'd5, 5'd0, 32'd0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'hA5A5_0001, 1'b0, 1'b0);
      bubble();
      bubble();
      bubble();
      step(1'b0, 1'b0, 1'b0, 5'd0, 5'd5, 32'd0, 1'b0, 1'b0);
      checkVal("r5_regfile_read", ex_source_data, 32'hA5A5_0001);

      // Dependent pair: forward from EX, then from MEM
      step(1'b0, 1'b0, 1'b1, 5'd7, 5'd0, 32'd0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 5'd0, 5'd7, 32'h0000_1234, 1'b1, 1'b0);
      checkVal("fwd_ex", ex_source_data, 32'h0000_1234);
      step(1'b0, 1'b0, 1'b0, 5'd0, 5'd7, 32'h0000_BEEF, 1'b0, 1'b1);
      checkVal("fwd_mem", ex_source_data, 32'h0000_1234);

      // WB write-through on r3
      step(1'b0, 1'b0, 1'b1, 5'd3, 5'd0, 32'd0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'h3333_0003, 1'b0, 1'b0);
      bubble();
      checkVal("r3_in_wb", 32'(wb_dreg_write), 32'd1);
      step(1'b0, 1'b0, 1'b0, 5'd0, 5'd3, 32'd0, 1'b0, 1'b0);
      checkVal("wb_write_through", ex_source_data, 32'h3333_0003);

      // Writes to r0 are dropped
      step(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0);
      checkVal("r0_ex_write", 32'(ex_dreg_write), 32'd0);
      step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
      bubble();
      bubble();
      step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0);
      checkVal("r0_read", ex_source_data, 32'd0);

      // Stall with r9 in WB, then flush under stall, then commit
      step(1'b0, 1'b0, 1'b1, 5'd9, 5'd3, 32'd0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 5'd10, 5'd5, 32'h9999_0009, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'h1010_0010, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 5'd11, 5'd9, 32'h7777_7777, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 5'd11, 5'd9, 32'h6666_6666, 1'b1, 1'b0);
      checkVal("stall_ex_hold", 32'(ex_dest_addr), 32'd0);
      checkVal("stall_mem_hold", 32'(mem_dest_addr), 32'd10);
      checkVal("stall_wb_hold", 32'(wb_dreg_write), 32'd1);
      step(1'b1, 1'b1, 1'b1, 5'd12, 5'd9, 32'd0, 1'b0, 1'b0);
      checkVal("flush_stall_ex", 32'(ex_dreg_write), 32'd0);
      checkVal("flush_stall_mem", 32'(mem_dest_addr), 32'd10);
      step(1'b0, 1'b1, 1'b1, 5'd13, 5'd0, 32'd0, 1'b0, 1'b0);
      checkVal("flush_ex_bubble", 32'(ex_dest_addr), 32'd0);
      bubble();
      bubble();
      step(1'b0, 1'b0, 1'b0, 5'd0, 5'd9, 32'd0, 1'b0, 1'b0);
      checkVal("r9_after_stall", ex_source_data, 32'h9999_0009);

      // Random traffic over a small register window
      for (int n = 0; n < 80; n++) begin
         step(1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 7) == 0),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              32'($urandom), 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0));
      end

      // Mid-operation reset zeroes everything immediately
      step(1'b0, 1'b0, 1'b1, 5'd6, 5'd2, 32'h0BAD_F00D, 1'b0, 1'b0);
      #3;
      rst_n = 1'b0;
      #1;
      checkAllZero("mid_reset");
      modelReset();
      stall = 1'b0; flush_ex = 1'b0; id_dreg_write = 1'b0; id_dest_addr = '0;
      id_source_addr = '0; ex_result = '0; ex_dfwd_sel = 1'b0; mem_dfwd_sel = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 1; i < 8; i++) begin
         step(1'b0, 1'b0, 1'b0, 5'd0, 5'(i), 32'd0, 1'b0, 1'b0);
         checkVal("post_reset_read", ex_source_data, 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
